dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  Responder for the core's DMA command interface (dma_en/read_addr/write_addr/byte_length -> dma_done).
//  Copies a block of memory word by word over a single-port memory master, staging up to
//  BUF_DEPTH words in an internal FIFO between read and write phases. Sits beside the DCache controller.
//  Pulses dma_done when the copy completes.
// PARAMETERS
//  ADDR_W     32  address width
//  LEN_W      32  byte_length width
//  BUF_DEPTH  4   staging FIFO depth in 32-bit words (power of 2, >=2); max words per read/write phase
// PORTS
//  clk          in   1       clock; all logic on the rising edge
//  rst_n        in   1       synchronous reset, active low
//  dma_en       in   1       command valid (level; held while the core stalls)
//  read_addr    in   ADDR_W  source byte address; bits[1:0] ignored (forced 0)
//  write_addr   in   ADDR_W  destination byte address; bits[1:0] ignored
//  byte_length  in   LEN_W   transfer length in bytes
//  dma_done     out  1       one-cycle completion pulse
//  mem_req      out  1       memory request
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  word-aligned byte address
//  mem_wdata    out  32      write data
//  mem_be       out  4       byte enables (always 4'hF without DMA_BYTE_TAIL_EN)
//  mem_ack      in   1       request accepted/completed; mem_rdata valid this cycle on reads
//  mem_rdata    in   32      read data
// BEHAVIOUR
//  Reset: state=IDLE; dma_done, mem_req, mem_we = 0; mem_addr, mem_wdata = 0; mem_be = 4'hF; FIFO empty.
//  Reset mid-transfer aborts immediately; no dma_done pulse; partial writes are not undone.
//  FSM IDLE -> RD -> WR -> (RD | DONE) -> HOLD -> IDLE.
//   IDLE: dma_en=1 latches src, dst, words=byte_length>>2 (rounded per CONFIGURATION); words=0 -> DONE.
//   RD: issue reads at src, src+4, ... until FIFO full or no words remain to read -> WR.
//   WR: pop FIFO, write to dst, dst+4, ...; FIFO empty: remaining>0 -> RD, else -> DONE.
//   DONE: dma_done=1 for exactly one cycle -> HOLD.
//   HOLD: wait for dma_en=0 -> IDLE (a command still held high after completion never retriggers).
//  Handshake: mem_req/mem_we/mem_addr/mem_wdata/mem_be stable from assertion until the mem_ack cycle.
//   On the ack cycle the engine advances; next beat is presented the following cycle (mem_req may stay high).
//   Read data is pushed into the FIFO on the ack cycle. mem_ack while mem_req=0 is ignored.
//  Timing: zero wait-state memory -> one beat per 2 cycles; words=0 -> dma_done 2 cycles after dma_en seen.
//  Arithmetic: addresses increment by 4 modulo 2^ADDR_W (wrap permitted, no error).
//   Remaining-word counter is LEN_W-2 bits; FIFO pointers are log2(BUF_DEPTH)+1 bits.
//  Command inputs are sampled only in IDLE; changes while busy are ignored.
// CONFIGURATION
//  DMA_BYTE_TAIL_EN defined: if byte_length[1:0]!=0, one extra final word is read and written with
//   mem_be = (1<<byte_length[1:0])-1 on the last write only; all other beats use 4'hF.
//  Not defined: byte_length[1:0] ignored (length truncated to whole words); mem_be tied 4'hF.
// STRUCTURE
//  Shared package (dma_pkg): state encoding localparams (IDLE, RD, WR, DONE, HOLD), WORD_BYTES=4, BE_FULL=4'hF.
//  Sub-module dma_word_fifo: synchronous FIFO (BUF_DEPTH x 32) with push/pop/full/empty; same clk/rst_n.
//  Top: FSM, address/length counters, memory port registers.
// TESTING
//  1. src=0x100, dst=0x200, len=16, ack at 0 waits -> 4 reads, then 4 writes to 0x200..0x20C
//     with matching data, single dma_done pulse.
//  2. len=40, BUF_DEPTH=4, random ack delays 0-3 -> phase pattern R4 W4 R4 W4 R2 W2; all 10 words copied.
//  3. len=0 with dma_en high -> no mem_req ever; dma_done high 2 cycles later for 1 cycle.
//  4. dma_en held high 20 cycles after dma_done -> no further mem_req;
//     drop then re-raise dma_en -> new copy starts.
//  5. rst_n=0 during WR of word 2 of 4 -> next cycle all outputs at reset values; no dma_done;
//     idle until next command.
//  6. DMA_BYTE_TAIL_EN, len=6 -> 2 reads, 2 writes; second write mem_be=4'h3.
//     Without macro: 1 read, 1 write.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared state encoding and constants for the DMA copy engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    HOLD
  } dma_state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_FULL    = 4'hF;

  // Byte enables for a final partial word holding rem (1..3) valid bytes.
  function automatic logic [3:0] tail_be(input logic [1:0] rem);
    case (rem)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return BE_FULL;
    endcase
  endfunction

endpackage

// File: rtl/dma_word_fifo.sv
// Synchronous staging FIFO with first-word-fall-through read data; zero-latency pop, one-cycle push-to-visible.
// Push while full and pop while empty are ignored; the owner is expected to respect full_o/empty_o.
module dma_word_fifo #(
  parameter int DEPTH = 4,
  parameter int DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DAT_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [DAT_W-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [DAT_W-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_dat_o = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/dma_copy_engine.sv
// Block copy engine: reads up to BUF_DEPTH words into a FIFO, then drains them to the destination; one beat per 2 cycles at best.
// DMA_BYTE_TAIL_EN (optional macro) adds a trailing partial word written with reduced byte enables.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [LEN_W-1:0]  byte_length,
  output logic              dma_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [LEN_W-3:0]  ONE_WORD  = (LEN_W-2)'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

  dma_state_e        state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-3:0]  rd_left_q;
  logic [LEN_W-3:0]  wr_left_q;
  logic [3:0]        last_be_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              done_q;

  logic [LEN_W-3:0]  words_d;
  logic [3:0]        last_be_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_rdata;
  logic              unused_addr_lsbs;

`ifdef DMA_BYTE_TAIL_EN
  assign words_d   = byte_length[LEN_W-1:2] + (LEN_W-2)'(|byte_length[1:0]);
  assign last_be_d = tail_be(byte_length[1:0]);
`else
  assign words_d   = byte_length[LEN_W-1:2];
  assign last_be_d = BE_FULL;
`endif

  // Sub-word address bits and (by default) the length remainder carry no meaning here.
  assign unused_addr_lsbs = ^{read_addr[1:0], write_addr[1:0], byte_length[1:0]};

  assign fifo_push = (state_q == RD) && req_q && mem_ack;
  assign fifo_pop  = (state_q == WR) && !req_q && !fifo_empty;

  dma_word_fifo #(
    .DEPTH (BUF_DEPTH),
    .DAT_W (32)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_dat_i (mem_rdata),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      last_be_q <= BE_FULL;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= BE_FULL;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dma_en) begin
            src_q     <= {read_addr[ADDR_W-1:2], 2'b00};
            dst_q     <= {write_addr[ADDR_W-1:2], 2'b00};
            rd_left_q <= words_d;
            wr_left_q <= words_d;
            last_be_q <= last_be_d;
            state_q   <= (words_d == '0) ? DONE : RD;
          end
        end

        // Each beat: present for as long as it takes to be acked, then one idle cycle.
        RD: begin
          if (req_q) begin
            if (mem_ack) begin
              req_q     <= 1'b0;
              src_q     <= src_q + ADDR_STEP;
              rd_left_q <= rd_left_q - ONE_WORD;
            end
          end else if (rd_left_q != '0 && !fifo_full) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= src_q;
            be_q   <= BE_FULL;
          end else begin
            state_q <= WR;
          end
        end

        WR: begin
          if (req_q) begin
            if (mem_ack) begin
              req_q     <= 1'b0;
              we_q      <= 1'b0;
              be_q      <= BE_FULL;
              dst_q     <= dst_q + ADDR_STEP;
              wr_left_q <= wr_left_q - ONE_WORD;
            end
          end else if (!fifo_empty) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            wdata_q <= fifo_rdata;
            be_q    <= (wr_left_q == ONE_WORD) ? last_be_q : BE_FULL;
          end else begin
            state_q <= (wr_left_q != '0) ? RD : DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          state_q <= HOLD;
        end

        // A level command still high after completion must not start a second copy.
        HOLD: begin
          if (!dma_en) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dma_done  = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: table vectors, hand-written corner sequences and random copies vs a word-level memory model.
module tb_dma_copy_engine;

  localparam int BUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_en = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] write_addr = '0;
  logic [31:0] byte_length = '0;
  logic        dma_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dma_copy_engine #(
    .ADDR_W    (32),
    .LEN_W     (32),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dma_en      (dma_en),
    .read_addr   (read_addr),
    .write_addr  (write_addr),
    .byte_length (byte_length),
    .dma_done    (dma_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [3:0]  wr_be_log[$];
  bit          op_log[$];
  int          dly_min = 0, dly_max = 0, cur_dly = 0, wait_cnt = 0;
  int          req_cnt = 0, done_cnt = 0;
  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [68:0] p_bus = '0;
  logic [31:0] old_w, be_mask;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(negedge clk) begin
    if (mem_req) req_cnt++;
    if (dma_done) done_cnt++;
    if (p_req && !p_ack && mem_req)
      chk("req_stable", {mem_we, mem_addr, mem_wdata, mem_be}, p_bus);
    p_req = mem_req;
    p_bus = {mem_we, mem_addr, mem_wdata, mem_be};
    if (mem_req && wait_cnt >= cur_dly) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        old_w   = rd_mem(mem_addr);
        be_mask = mask_of(mem_be);
        mem[mem_addr] = (mem_wdata & be_mask) | (old_w & ~be_mask);
        wr_addr_log.push_back(mem_addr);
        wr_be_log.push_back(mem_be);
      end else begin
        mem_rdata = rd_mem(mem_addr);
        rd_log.push_back(mem_addr);
      end
      op_log.push_back(mem_we);
      wait_cnt = 0;
      cur_dly  = $urandom_range(dly_max, dly_min);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) wait_cnt++;
      else wait_cnt = 0;
    end
    p_ack = mem_ack;
  end

  // ---------------- reference rules ----------------
  function automatic int exp_words(input logic [31:0] len);
`ifdef DMA_BYTE_TAIL_EN
    return int'(len / 4) + ((len % 4 != 0) ? 1 : 0);
`else
    return int'(len / 4);
`endif
  endfunction

  function automatic logic [3:0] exp_last_be(input logic [31:0] len);
`ifdef DMA_BYTE_TAIL_EN
    if (len % 4 != 0) return 4'((1 << (len % 4)) - 1);
`endif
    return 4'hF;
  endfunction

  function automatic string exp_pattern(input int words);
    string s = "";
    int rem = words;
    while (rem > 0) begin
      int k = (rem < BUF_DEPTH) ? rem : BUF_DEPTH;
      s = {s, $sformatf("R%0dW%0d", k, k)};
      rem -= k;
    end
    return s;
  endfunction

  function automatic string act_pattern();
    string s = "";
    int i = 0;
    while (i < op_log.size()) begin
      int j = i;
      while (j < op_log.size() && op_log[j] == op_log[i]) j++;
      s = {s, $sformatf("%s%0d", op_log[i] ? "W" : "R", j - i)};
      i = j;
    end
    return s;
  endfunction

  task automatic clear_logs();
    mem.delete();
    rd_log.delete();
    wr_addr_log.delete();
    wr_be_log.delete();
    op_log.delete();
  endtask

  task automatic run_copy(input string nm, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input int dmax, input int exp_rd,
                          input int exp_wr, input logic [3:0] exp_be);
    int w, r0, d0;
    logic [31:0] s, d, m, e;
    bit ok, seen;
    clear_logs();
    dly_min = 0;
    dly_max = dmax;
    cur_dly = 0;
    w = exp_words(len);
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    @(negedge clk);
    d0 = done_cnt;
    read_addr = src;
    write_addr = dst;
    byte_length = len;
    dma_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (dma_done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk({nm, "_hold_no_req"}, req_cnt - r0, 0);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    dma_en = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_rd_cnt"}, rd_log.size(), exp_rd);
    chk({nm, "_wr_cnt"}, wr_addr_log.size(), exp_wr);
    chk({nm, "_model_words"}, rd_log.size(), w);
    ok = 1'b1;
    foreach (rd_log[i]) if (rd_log[i] !== s + 32'(4 * i)) ok = 1'b0;
    foreach (wr_addr_log[i]) if (wr_addr_log[i] !== d + 32'(4 * i)) ok = 1'b0;
    chk({nm, "_addr_seq"}, ok, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < w; i++) begin
      m = mask_of((i == w - 1) ? exp_last_be(len) : 4'hF);
      e = (init_word(s + 32'(4 * i)) & m) | (init_word(d + 32'(4 * i)) & ~m);
      if (rd_mem(d + 32'(4 * i)) !== e) ok = 1'b0;
    end
    chk({nm, "_data"}, ok, 1'b1);
    ok = 1'b1;
    foreach (wr_be_log[i])
      if (wr_be_log[i] !== ((i == w - 1) ? exp_last_be(len) : 4'hF)) ok = 1'b0;
    chk({nm, "_be_seq"}, ok, 1'b1);
    if (exp_wr > 0) chk({nm, "_last_be"}, wr_be_log[wr_be_log.size() - 1], exp_be);
    chk_str({nm, "_phases"}, act_pattern(), exp_pattern(w));
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          dmax;
    int          rd;
    int          wr;
    logic [3:0]  be;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int r0, d0;
    bit found;
    logic [31:0] rs, rl;

    tbl[0] = '{32'h100, 32'h200, 32'd16, 0, 4, 4, 4'hF};
    tbl[1] = '{32'h1000, 32'h2000, 32'd40, 3, 10, 10, 4'hF};
    tbl[2] = '{32'h300, 32'h400, 32'd0, 1, 0, 0, 4'hF};
    tbl[4] = '{32'hFFFF_FFF8, 32'h40, 32'd16, 1, 4, 4, 4'hF};
`ifdef DMA_BYTE_TAIL_EN
    tbl[3] = '{32'h500, 32'h600, 32'd6, 2, 2, 2, 4'h3};
    tbl[5] = '{32'h103, 32'h707, 32'd7, 0, 2, 2, 4'h7};
    tbl[6] = '{32'h800, 32'h900, 32'd3, 2, 1, 1, 4'h7};
    tbl[7] = '{32'hA00, 32'hB00, 32'd33, 3, 9, 9, 4'h1};
`else
    tbl[3] = '{32'h500, 32'h600, 32'd6, 2, 1, 1, 4'hF};
    tbl[5] = '{32'h103, 32'h707, 32'd7, 0, 1, 1, 4'hF};
    tbl[6] = '{32'h800, 32'h900, 32'd3, 2, 0, 0, 4'hF};
    tbl[7] = '{32'hA00, 32'hB00, 32'd33, 3, 8, 8, 4'hF};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", mem_be, 4'hF);
    chk("rst_done", dma_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive copies also exercise drop-then-re-raise of dma_en after a hold.
    for (int i = 0; i < 8; i++)
      run_copy($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].dmax,
               tbl[i].rd, tbl[i].wr, tbl[i].be);

    // Zero length: done exactly two edges after the command is sampled, no memory traffic.
    @(negedge clk);
    r0 = req_cnt;
    byte_length = 32'd0;
    dma_en = 1'b1;
    @(negedge clk);
    chk("len0_done_c1", dma_done, 1'b0);
    @(negedge clk);
    chk("len0_done_c2", dma_done, 1'b1);
    @(negedge clk);
    chk("len0_done_c3", dma_done, 1'b0);
    dma_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("len0_no_req", req_cnt - r0, 0);

    // Reset while the second of four writes is waiting for its ack.
    clear_logs();
    dly_min = 2;
    dly_max = 2;
    cur_dly = 2;
    @(negedge clk);
    read_addr = 32'h100;
    write_addr = 32'h200;
    byte_length = 32'd16;
    dma_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_addr == 32'h204) found = 1'b1;
    end
    chk("midrst_reached_wr2", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_addr", mem_addr, 32'h0);
    chk("midrst_wdata", mem_wdata, 32'h0);
    chk("midrst_be", mem_be, 4'hF);
    chk("midrst_done", dma_done, 1'b0);
    dma_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    r0 = req_cnt;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", req_cnt - r0, 0);
    chk("midrst_partial_wr", wr_addr_log.size(), 1);

    // Random copies against the model.
    for (int i = 0; i < 6; i++) begin
      rs = $urandom;
      rl = $urandom_range(60, 0);
      run_copy($sformatf("rnd%0d", i), rs, rs ^ 32'h8000_0000, rl, 3,
               exp_words(rl), exp_words(rl), exp_last_be(rl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
